// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: payment state encoding, coin values
// and the default money width.
package vm_pkg;

    localparam int DEF_MONEY_W = 8;

    localparam int COIN_1  = 1;
    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_COLLECT = 2'd1,
        PS_SUCCESS = 2'd2,
        PS_REFUND  = 2'd3
    } pay_state_t;

endpackage

// File: rtl/sec_tick.sv
// One-second tick generator: counts 0..TICK_DIV-1 and pulses tick on the wrap.
// clr restarts the count so the following second is a full one.
module sec_tick #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // tick ignores clr so the FSM can still see a tick landing on a state change
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/payment_unit.sv
// Coin collection against a latched price, with payment timeout, result
// display window and a one-cycle finish pulse back to the mode controller.
module payment_unit import vm_pkg::*; #(
    parameter int MONEY_W   = DEF_MONEY_W,
    parameter int TICK_DIV  = 100000000,
    parameter int TIMEOUT_S = 30,
    parameter int DISP_S    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MONEY_W-1:0] price,
    input  logic               coin_1,
    input  logic               coin_5,
    input  logic               coin_10,
    input  logic               cancel,
    output logic [MONEY_W-1:0] money,
    output logic [MONEY_W-1:0] change,
    output logic               paid,
    output logic               fail,
    output logic               busy,
    output logic [5:0]         secs_left,
    output logic               finish
);

    pay_state_t         state, nstate;
    logic [MONEY_W-1:0] price_q, price_n, money_n, change_n;
    logic [5:0]         secs_n;
    logic               finish_n;
    logic               tick;
    logic [MONEY_W:0]   sum;
    logic [MONEY_W-1:0] sat;

    sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (nstate != state),
        .tick (tick)
    );

    // One extra bit catches overflow; the total clamps at all-ones.
    assign sum = {1'b0, money}
               + (coin_1  ? (MONEY_W+1)'(COIN_1)  : '0)
               + (coin_5  ? (MONEY_W+1)'(COIN_5)  : '0)
               + (coin_10 ? (MONEY_W+1)'(COIN_10) : '0);
    assign sat = sum[MONEY_W] ? '1 : sum[MONEY_W-1:0];

    always_comb begin
        nstate   = state;
        price_n  = price_q;
        money_n  = money;
        change_n = change;
        secs_n   = secs_left;
        finish_n = 1'b0;
        case (state)
            PS_IDLE: begin
                if (start) begin
                    price_n = price;
                    money_n = '0;
                    secs_n  = 6'(TIMEOUT_S);
                    nstate  = PS_COLLECT;
                end
            end
            PS_COLLECT: begin
                money_n = sat;
                // A completing coin beats a same-cycle cancel or timeout.
                if (sat >= price_q) begin
                    nstate   = PS_SUCCESS;
                    change_n = sat - price_q;
                    secs_n   = 6'(DISP_S);
                end else if (cancel || (tick && secs_left == 6'd1)) begin
                    nstate   = PS_REFUND;
                    change_n = sat;
                    secs_n   = 6'(DISP_S);
                end else if (tick) begin
                    secs_n = secs_left - 6'd1;
                end
            end
            PS_SUCCESS, PS_REFUND: begin
                if (tick) begin
                    if (secs_left == 6'd1) begin
                        nstate   = PS_IDLE;
                        finish_n = 1'b1;
                        money_n  = '0;
                        change_n = '0;
                        secs_n   = '0;
                    end else begin
                        secs_n = secs_left - 6'd1;
                    end
                end
            end
            default: nstate = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PS_IDLE;
            price_q   <= '0;
            money     <= '0;
            change    <= '0;
            secs_left <= '0;
            paid      <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            state     <= nstate;
            price_q   <= price_n;
            money     <= money_n;
            change    <= change_n;
            secs_left <= secs_n;
            paid      <= (nstate == PS_SUCCESS);
            fail      <= (nstate == PS_REFUND);
            busy      <= (nstate != PS_IDLE);
            finish    <= finish_n;
        end
    end

endmodule

// File: tb/tb_payment_unit.sv
// Scoreboarded bench for payment_unit: a transaction-level model predicts each
// payment outcome; a negedge monitor checks results, display timing and idle state.
module tb_payment_unit;

    localparam int TD = 4;
    localparam int TO = 3;
    localparam int DS = 2;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 0, coin_1 = 0, coin_5 = 0, coin_10 = 0, cancel = 0;
    logic [MW-1:0] price = '0;
    logic [MW-1:0] money, change;
    logic          paid, fail, busy, finish;
    logic [5:0]    secs_left;

    logic          s_start = 0, s_c1 = 0, s_c5 = 0, s_c10 = 0, s_cancel = 0;
    logic [MW-1:0] s_price = '0;
    logic [MW-1:0] s_money, s_change;
    logic          s_paid, s_fail, s_busy, s_finish;
    logic [5:0]    s_secs;

    payment_unit #(.MONEY_W(MW), .TICK_DIV(TD), .TIMEOUT_S(TO), .DISP_S(DS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .price(price),
        .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10), .cancel(cancel),
        .money(money), .change(change), .paid(paid), .fail(fail), .busy(busy),
        .secs_left(secs_left), .finish(finish)
    );

    // Long timeout so the saturation case can pile up coins.
    payment_unit #(.MONEY_W(MW), .TICK_DIV(TD), .TIMEOUT_S(30), .DISP_S(DS)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .price(s_price),
        .coin_1(s_c1), .coin_5(s_c5), .coin_10(s_c10), .cancel(s_cancel),
        .money(s_money), .change(s_change), .paid(s_paid), .fail(s_fail), .busy(s_busy),
        .secs_left(s_secs), .finish(s_finish)
    );

    typedef struct {
        logic paid;
        int   money;
        int   change;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] stim[$];   // per COLLECT cycle: {cancel, coin_10, coin_5, coin_1}
    int         total = 0;
    int         bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Outcome of a payment from the rules: accumulate, then pay / cancel / timeout.
    function automatic exp_t model(input int pr, output int d);
        exp_t       e;
        int         m = 0;
        logic [3:0] v;
        e = '{1'b0, 0, 0};
        d = 0;
        for (int c = 0; c < TO * TD; c++) begin
            v = (c < stim.size()) ? stim[c] : 4'd0;
            m += (v[0] ? 1 : 0) + (v[1] ? 5 : 0) + (v[2] ? 10 : 0);
            if (m > 255) m = 255;
            if (m >= pr) begin
                e = '{1'b1, m, m - pr};
                d = c;
                return e;
            end
            if (v[3] || c == TO * TD - 1) begin
                e = '{1'b0, m, m};
                d = c;
                return e;
            end
        end
        return e;
    endfunction

    // Monitor
    logic prev_dec = 0, prev_fin = 0;
    int   dcnt = 0;
    exp_t got_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dec = 0;
            prev_fin = 0;
        end else begin
            if ((paid || fail) && !prev_dec) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    check("paid", int'(paid), int'(got_e.paid));
                    check("fail", int'(fail), int'(!got_e.paid));
                    check("money_result", int'(money), got_e.money);
                    check("change", int'(change), got_e.change);
                end
                dcnt = 0;
            end
            if (paid || fail) begin
                dcnt++;
                check("paid_fail_excl", int'(paid && fail), 0);
            end
            if (finish) check("finish_latency", dcnt, DS * TD);
            if (prev_fin) check("finish_width", int'(finish), 0);
            if (!busy) begin
                check("idle_money", int'(money), 0);
                check("idle_change", int'(change), 0);
                check("idle_secs", int'(secs_left), 0);
                check("idle_status", int'(paid || fail), 0);
            end
            prev_dec = paid || fail;
            prev_fin = finish;
        end
    end

    task automatic set_inputs(input logic [4:0] v);
        coin_1  = v[0];
        coin_5  = v[1];
        coin_10 = v[2];
        cancel  = v[3];
        start   = v[4];
    endtask

    task automatic run_txn(input int pr);
        exp_t       e;
        int         d, m;
        logic [3:0] v;
        logic       got;
        e = model(pr, d);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        price = MW'(pr);
        @(posedge clk); #1;
        start = 1'b0;
        price = MW'($urandom);
        m = 0;
        for (int c = 0; c <= d; c++) begin
            check("secs_collect", int'(secs_left), TO - c / TD);
            check("money_collect", int'(money), m);
            v = (c < stim.size()) ? stim[c] : 4'd0;
            set_inputs({1'b0, v});
            m += (v[0] ? 1 : 0) + (v[1] ? 5 : 0) + (v[2] ? 10 : 0);
            @(posedge clk); #1;
        end
        // Noise during the display window must be ignored.
        for (int i = 0; i < DS * TD - 2; i++) begin
            set_inputs(5'($urandom));
            @(posedge clk); #1;
        end
        set_inputs('0);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (finish) begin
                got = 1;
                break;
            end
        end
        if (!got) check("finish_seen", 0, 1);
        // Coins and cancel in IDLE must leave everything at zero.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            set_inputs({1'b0, 4'($urandom) | 4'b0100});
        end
        @(posedge clk); #1;
        set_inputs('0);
    endtask

    initial begin
        #3;
        check("rst_money", int'(money), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        stim.delete(); stim.push_back(4'b0100); stim.push_back(4'b0010);
        run_txn(15);                                   // exact pay
        stim.delete(); stim.push_back(4'b0110);
        run_txn(12);                                   // overpay, simultaneous coins
        stim.delete(); stim.push_back(4'b0010); stim.push_back(4'b1000);
        run_txn(20);                                   // cancel
        stim.delete();
        run_txn(20);                                   // timeout
        stim.delete(); stim.push_back(4'b1100);
        run_txn(10);                                   // coin beats cancel
        stim.delete(); stim.push_back(4'b1000);
        run_txn(0);                                    // zero price

        // Asynchronous reset mid-COLLECT
        @(posedge clk); #1;
        start = 1'b1; price = 8'd50;
        @(posedge clk); #1;
        start = 1'b0; coin_5 = 1'b1;
        @(posedge clk); #1;
        coin_5 = 1'b0; coin_1 = 1'b1;
        @(posedge clk); #1;
        coin_1 = 1'b0;
        check("mid_money", int'(money), 6);
        check("mid_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_money", int'(money), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_secs", int'(secs_left), 0);
        check("arst_status", int'(paid || fail || finish), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 25; t++) begin
            stim.delete();
            for (int c = 0; c < int'($urandom_range(0, 14)); c++)
                stim.push_back({($urandom_range(0, 11) == 0), 3'($urandom)});
            run_txn(int'($urandom_range(0, 60)));
        end

        // Saturation on the long-timeout instance
        @(posedge clk); #1;
        s_start = 1'b1; s_price = 8'd255;
        @(posedge clk); #1;
        s_start = 1'b0; s_c1 = 1'b1; s_c5 = 1'b1; s_c10 = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        s_c1 = 1'b0; s_c5 = 1'b0;
        check("sat_money_240", int'(s_money), 240);
        @(posedge clk); #1;
        check("sat_money_250", int'(s_money), 250);
        check("sat_not_paid", int'(s_paid), 0);
        check("sat_busy", int'(s_busy), 1);
        @(posedge clk); #1;
        s_c10 = 1'b0;
        check("sat_money_255", int'(s_money), 255);
        check("sat_change", int'(s_change), 0);
        check("sat_paid", int'(s_paid), 1);
        check("sat_fail", int'(s_fail), 0);
        begin
            logic got;
            got = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (s_finish) begin
                    got = 1;
                    break;
                end
            end
            check("sat_finish_seen", int'(got), 1);
        end
        @(negedge clk);
        check("sat_idle_money", int'(s_money), 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
